// File: rtl/dmem_checker.sv
// -----------------------------------------------------------------------------
// dmem_checker
//
// Hardware self-check stage that sits behind the processor toplevel's
// data-memory debug port. After a start pulse it waits START_DELAY cycles so
// the program can finish. It then walks an external vector table of
// (address, expected word) pairs. For each vector it drives the address onto
// the debug port, waits RD_LAT cycles and compares the returned word against
// the expected word. Pass/fail results are accumulated as it goes.
//
// Parameters:
//   N_TESTS      number of vectors to check (0..255)
//   START_DELAY  settle cycles between start and the first vector
//   RD_LAT       cycles from a dbg_addr update to valid dbg_data (>= 1)
//
// Ports:
//   clk            system clock, all logic on the rising edge
//   rst            synchronous active-high reset
//   start          one-cycle pulse, starts a run from IDLE or DONE
//   vec_idx        index of the vector currently requested from the table
//   vec_addr       table address for vec_idx (combinational from the table)
//   vec_data       expected word for vec_idx (combinational from the table)
//   dbg_addr       registered address to the toplevel debug read port
//   dbg_data       toplevel debug read data
//   busy           high while settling or checking vectors
//   done           high once a run has completed
//   pass           valid with done, 1 when no mismatch was seen
//   err_cnt        mismatch count, saturating at 255
//   first_err_idx  index of the first mismatch, 8'hFF if none
//   first_err_got  dbg_data captured at the first mismatch
//
// Optional feature:
//   DMEM_CHECKER_STOP_ON_ERR_EN  when defined, the first mismatch ends the run
//                                immediately, leaving vec_idx on the failing
//                                vector.
// -----------------------------------------------------------------------------
module dmem_checker #(
  parameter int N_TESTS     = 16,
  parameter int START_DELAY = 5000,
  parameter int RD_LAT      = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  output logic [7:0]  vec_idx,
  input  logic [7:0]  vec_addr,
  input  logic [31:0] vec_data,
  output logic [7:0]  dbg_addr,
  input  logic [31:0] dbg_data,
  output logic        busy,
  output logic        done,
  output logic        pass,
  output logic [7:0]  err_cnt,
  output logic [7:0]  first_err_idx,
  output logic [31:0] first_err_got
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SETTLE,
    S_ISSUE,
    S_WAIT,
    S_DONE
  } state_t;

  // A zero settle delay still spends one cycle in SETTLE, so the load value
  // is clamped at zero rather than wrapping.
  localparam logic [31:0] SETTLE_LOAD = (START_DELAY > 0) ? 32'(START_DELAY - 1) : 32'd0;
  localparam logic [31:0] WAIT_LOAD   = (RD_LAT > 1) ? 32'(RD_LAT - 1) : 32'd0;
  localparam logic [7:0]  LAST_IDX    = (N_TESTS > 0) ? 8'(N_TESTS - 1) : 8'd0;
  localparam bit          NO_TESTS    = (N_TESTS == 0);

  state_t      state;
  logic [31:0] cnt;
  logic [31:0] expected;
  logic        mismatch;
  logic        stop_now;
  logic        last_vec;

  assign mismatch = (dbg_data != expected);
  assign last_vec = (vec_idx == LAST_IDX);

`ifdef DMEM_CHECKER_STOP_ON_ERR_EN
  assign stop_now = mismatch;
`else
  assign stop_now = 1'b0;
`endif

  // Single-process FSM; every output is a register updated on the
  // transitions. cnt is shared between the settle delay and the read-latency
  // wait because those two phases never overlap.
  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= S_IDLE;
      cnt           <= 32'd0;
      expected      <= 32'd0;
      dbg_addr      <= 8'd0;
      vec_idx       <= 8'd0;
      busy          <= 1'b0;
      done          <= 1'b0;
      pass          <= 1'b0;
      err_cnt       <= 8'd0;
      first_err_idx <= 8'hFF;
      first_err_got <= 32'd0;
    end else begin
      case (state)
        S_IDLE, S_DONE: begin
          if (start) begin
            state         <= S_SETTLE;
            cnt           <= SETTLE_LOAD;
            vec_idx       <= 8'd0;
            busy          <= 1'b1;
            done          <= 1'b0;
            pass          <= 1'b0;
            err_cnt       <= 8'd0;
            first_err_idx <= 8'hFF;
            first_err_got <= 32'd0;
          end
        end

        S_SETTLE: begin
          if (cnt == 32'd0) begin
            if (NO_TESTS) begin
              // An empty table is a trivially passing run.
              state <= S_DONE;
              busy  <= 1'b0;
              done  <= 1'b1;
              pass  <= 1'b1;
            end else begin
              state <= S_ISSUE;
            end
          end else begin
            cnt <= cnt - 32'd1;
          end
        end

        S_ISSUE: begin
          dbg_addr <= vec_addr;
          expected <= vec_data;
          cnt      <= WAIT_LOAD;
          state    <= S_WAIT;
        end

        S_WAIT: begin
          if (cnt != 32'd0) begin
            cnt <= cnt - 32'd1;
          end else begin
            if (mismatch) begin
              // err_cnt is still zero exactly until the first mismatch, so
              // it doubles as the "first error" flag.
              if (err_cnt == 8'd0) begin
                first_err_idx <= vec_idx;
                first_err_got <= dbg_data;
              end
              if (err_cnt != 8'hFF) begin
                err_cnt <= err_cnt + 8'd1;
              end
            end
            if (last_vec || stop_now) begin
              state <= S_DONE;
              busy  <= 1'b0;
              done  <= 1'b1;
              pass  <= (err_cnt == 8'd0) && !mismatch;
            end else begin
              vec_idx <= vec_idx + 8'd1;
              state   <= S_ISSUE;
            end
          end
        end

        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_dmem_checker.sv
// -----------------------------------------------------------------------------
// tb_dmem_checker
//
// Self-checking bench for dmem_checker. Five instances cover different
// parameter sets. All of them share one vector table and one memory image.
// Each instance has its own debug-port read model with a configurable latency.
// A behavioural model walks the table with plain loops and predicts the run
// length and every result register. Only one instance is started at a time.
// -----------------------------------------------------------------------------
module tb_dmem_checker;

  localparam int NI = 5;
  // Per-instance parameters: vectors, settle delay, DUT read latency and the
  // latency of the memory model wired to that instance.
  localparam int P_N [NI] = '{3, 4, 4, 0, 255};
  localparam int P_D [NI] = '{4, 3, 2, 0, 1};
  localparam int P_L [NI] = '{1, 3, 2, 1, 1};
  localparam int P_M [NI] = '{1, 3, 3, 1, 1};

  logic        clk = 1'b0;
  logic        rst;
  logic        start         [NI];
  logic [7:0]  vec_idx       [NI];
  logic [7:0]  vec_addr      [NI];
  logic [31:0] vec_data      [NI];
  logic [7:0]  dbg_addr      [NI];
  logic [31:0] dbg_data      [NI];
  logic        busy          [NI];
  logic        done          [NI];
  logic        pass          [NI];
  logic [7:0]  err_cnt       [NI];
  logic [7:0]  first_err_idx [NI];
  logic [31:0] first_err_got [NI];

  logic [7:0]  tbl_addr [256];
  logic [31:0] tbl_data [256];
  logic [31:0] mem      [256];
  logic [7:0]  pipe0    [NI] = '{default: 8'd0};
  logic [7:0]  pipe1    [NI] = '{default: 8'd0};

  int checks = 0;
  int errors = 0;

  // Model results for the run about to start.
  int exp_err, exp_first, exp_cycles, exp_last;
  logic [31:0] exp_got;
  bit exp_got_known;

  // 10 ns clock.
  always #5 clk = ~clk;

  // The vector table answers combinationally on vec_idx. The debug read data
  // comes from the memory image, looked up through an address delay line of
  // the model's latency. A 1-cycle model is a plain async read.
  always_comb begin
    for (int k = 0; k < NI; k++) begin
      vec_addr[k] = tbl_addr[vec_idx[k]];
      vec_data[k] = tbl_data[vec_idx[k]];
      case (P_M[k])
        1:       dbg_data[k] = mem[dbg_addr[k]];
        2:       dbg_data[k] = mem[pipe0[k]];
        default: dbg_data[k] = mem[pipe1[k]];
      endcase
    end
  end

  // Address delay line feeding the slower memory models.
  always @(posedge clk) begin
    for (int k = 0; k < NI; k++) begin
      pipe0[k] <= dbg_addr[k];
      pipe1[k] <= pipe0[k];
    end
  end

  dmem_checker #(.N_TESTS(P_N[0]), .START_DELAY(P_D[0]), .RD_LAT(P_L[0])) u0 (
    .clk(clk), .rst(rst), .start(start[0]), .vec_idx(vec_idx[0]),
    .vec_addr(vec_addr[0]), .vec_data(vec_data[0]), .dbg_addr(dbg_addr[0]),
    .dbg_data(dbg_data[0]), .busy(busy[0]), .done(done[0]), .pass(pass[0]),
    .err_cnt(err_cnt[0]), .first_err_idx(first_err_idx[0]),
    .first_err_got(first_err_got[0]));

  dmem_checker #(.N_TESTS(P_N[1]), .START_DELAY(P_D[1]), .RD_LAT(P_L[1])) u1 (
    .clk(clk), .rst(rst), .start(start[1]), .vec_idx(vec_idx[1]),
    .vec_addr(vec_addr[1]), .vec_data(vec_data[1]), .dbg_addr(dbg_addr[1]),
    .dbg_data(dbg_data[1]), .busy(busy[1]), .done(done[1]), .pass(pass[1]),
    .err_cnt(err_cnt[1]), .first_err_idx(first_err_idx[1]),
    .first_err_got(first_err_got[1]));

  dmem_checker #(.N_TESTS(P_N[2]), .START_DELAY(P_D[2]), .RD_LAT(P_L[2])) u2 (
    .clk(clk), .rst(rst), .start(start[2]), .vec_idx(vec_idx[2]),
    .vec_addr(vec_addr[2]), .vec_data(vec_data[2]), .dbg_addr(dbg_addr[2]),
    .dbg_data(dbg_data[2]), .busy(busy[2]), .done(done[2]), .pass(pass[2]),
    .err_cnt(err_cnt[2]), .first_err_idx(first_err_idx[2]),
    .first_err_got(first_err_got[2]));

  dmem_checker #(.N_TESTS(P_N[3]), .START_DELAY(P_D[3]), .RD_LAT(P_L[3])) u3 (
    .clk(clk), .rst(rst), .start(start[3]), .vec_idx(vec_idx[3]),
    .vec_addr(vec_addr[3]), .vec_data(vec_data[3]), .dbg_addr(dbg_addr[3]),
    .dbg_data(dbg_data[3]), .busy(busy[3]), .done(done[3]), .pass(pass[3]),
    .err_cnt(err_cnt[3]), .first_err_idx(first_err_idx[3]),
    .first_err_got(first_err_got[3]));

  dmem_checker #(.N_TESTS(P_N[4]), .START_DELAY(P_D[4]), .RD_LAT(P_L[4])) u4 (
    .clk(clk), .rst(rst), .start(start[4]), .vec_idx(vec_idx[4]),
    .vec_addr(vec_addr[4]), .vec_data(vec_data[4]), .dbg_addr(dbg_addr[4]),
    .dbg_data(dbg_data[4]), .busy(busy[4]), .done(done[4]), .pass(pass[4]),
    .err_cnt(err_cnt[4]), .first_err_idx(first_err_idx[4]),
    .first_err_got(first_err_got[4]));

  // Counts one comparison. Prints a FAIL line when observed and expected differ.
  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Compares every output of one instance against its reset values.
  task automatic checkReset(input int k);
    checkOutput($sformatf("rst_busy[%0d]", k), 32'(busy[k]), 32'd0);
    checkOutput($sformatf("rst_done[%0d]", k), 32'(done[k]), 32'd0);
    checkOutput($sformatf("rst_pass[%0d]", k), 32'(pass[k]), 32'd0);
    checkOutput($sformatf("rst_err_cnt[%0d]", k), 32'(err_cnt[k]), 32'd0);
    checkOutput($sformatf("rst_first_idx[%0d]", k), 32'(first_err_idx[k]), 32'hFF);
    checkOutput($sformatf("rst_first_got[%0d]", k), first_err_got[k], 32'd0);
    checkOutput($sformatf("rst_dbg_addr[%0d]", k), 32'(dbg_addr[k]), 32'd0);
    checkOutput($sformatf("rst_vec_idx[%0d]", k), 32'(vec_idx[k]), 32'd0);
  endtask

  // Reference model. It walks the table in order and decides each vector
  // from what the memory actually holds. If the memory model is slower than
  // the DUT's read latency, the word read is stale and every vector fails.
  // The stale value itself is not predicted.
  task automatic computeExpected(input int k);
    logic [31:0] word;
    bit lat_ok, bad;
    int ran;
    lat_ok = (P_M[k] <= P_L[k]);
    exp_err = 0; exp_first = 255; exp_got = 32'd0; exp_got_known = 1'b1;
    exp_last = 0; ran = 0;
    for (int i = 0; i < P_N[k]; i++) begin
      ran = i + 1;
      exp_last = i;
      word = mem[tbl_addr[i]];
      bad = !lat_ok || (word != tbl_data[i]);
      if (bad) begin
        if (exp_err == 0) begin
          exp_first = i;
          exp_got = word;
          exp_got_known = lat_ok;
        end
        if (exp_err < 255) exp_err++;
`ifdef DMEM_CHECKER_STOP_ON_ERR_EN
        break;
`endif
      end
    end
    exp_cycles = ((P_D[k] > 0) ? P_D[k] : 1) + ran * (1 + P_L[k]);
  endtask

  // Builds a random table of n distinct nonzero addresses. Roughly pct
  // percent of the expected words are corrupted.
  task automatic fillTable(input int n, input int pct);
    int base;
    logic [31:0] mask;
    base = $urandom_range(0, 254);
    for (int i = 0; i < n; i++) begin
      tbl_addr[i] = 8'(1 + ((base + i * 7) % 255));
      tbl_data[i] = mem[tbl_addr[i]];
      if ($urandom_range(0, 99) < pct) begin
        mask = $urandom | 32'd1;
        tbl_data[i] = tbl_data[i] ^ mask;
      end
    end
  endtask

  // Runs one check on instance k and compares the results with the model.
  // If poke_at >= 0, a second start pulse is sent that many cycles into the
  // run. That pulse must not change anything.
  task automatic applyStimulus(input int k, input int poke_at);
    int n, limit;
    logic [7:0] held_err;
    computeExpected(k);
    @(negedge clk);
    start[k] = 1'b1;
    @(posedge clk);
    #1;
    start[k] = 1'b0;
    checkOutput($sformatf("busy_after_start[%0d]", k), 32'(busy[k]), 32'd1);
    checkOutput($sformatf("cleared_err_cnt[%0d]", k), 32'(err_cnt[k]), 32'd0);
    n = 0;
    limit = exp_cycles + 20;
    while (!done[k] && n < limit) begin
      if (n == poke_at) start[k] = 1'b1;
      @(posedge clk);
      #1;
      start[k] = 1'b0;
      n++;
    end
    checkOutput($sformatf("run_cycles[%0d]", k), 32'(n), 32'(exp_cycles));
    checkOutput($sformatf("done[%0d]", k), 32'(done[k]), 32'd1);
    checkOutput($sformatf("busy_at_done[%0d]", k), 32'(busy[k]), 32'd0);
    checkOutput($sformatf("pass[%0d]", k), 32'(pass[k]), 32'(exp_err == 0));
    checkOutput($sformatf("err_cnt[%0d]", k), 32'(err_cnt[k]), 32'(exp_err));
    checkOutput($sformatf("first_err_idx[%0d]", k), 32'(first_err_idx[k]), 32'(exp_first));
    checkOutput($sformatf("vec_idx_at_done[%0d]", k), 32'(vec_idx[k]), 32'(exp_last));
    if (exp_got_known)
      checkOutput($sformatf("first_err_got[%0d]", k), first_err_got[k], exp_got);
    // DONE must hold its results while no new start arrives.
    held_err = err_cnt[k];
    repeat (3) @(posedge clk);
    #1;
    checkOutput($sformatf("done_held[%0d]", k), 32'(done[k]), 32'd1);
    checkOutput($sformatf("err_cnt_held[%0d]", k), 32'(err_cnt[k]), 32'(exp_err));
    checkOutput($sformatf("err_cnt_stable[%0d]", k), 32'(err_cnt[k]), 32'(held_err));
  endtask

  // Main sequence: reset, fixed table cases, mid-run reset, then randomized
  // runs on the other parameter sets.
  initial begin
    logic [31:0] r;
    rst = 1'b1;
    for (int k = 0; k < NI; k++) start[k] = 1'b0;
    // The low byte of each memory word is its own address, so no two
    // addresses ever hold the same word.
    for (int a = 0; a < 256; a++) begin
      r = $urandom;
      mem[a] = {r[31:8], 8'(a)};
      tbl_addr[a] = 8'd0;
      tbl_data[a] = 32'd0;
    end
    repeat (3) @(posedge clk);
    #1;
    for (int k = 0; k < NI; k++) checkReset(k);
    // Reset wins over a simultaneous start.
    start[0] = 1'b1;
    @(posedge clk);
    #1;
    start[0] = 1'b0;
    checkOutput("rst_beats_start", 32'(busy[0]), 32'd0);
    @(negedge clk);
    rst = 1'b0;

    // Small fixed table where every entry matches the memory.
    mem[0] = 32'd1; mem[4] = 32'd1; mem[8] = 32'd2;
    tbl_addr[0] = 8'h00; tbl_data[0] = 32'd1;
    tbl_addr[1] = 8'h04; tbl_data[1] = 32'd1;
    tbl_addr[2] = 8'h08; tbl_data[2] = 32'd2;
    $display("[TB] fixed table, all matching");
    applyStimulus(0, -1);
    $display("[TB] rerun from DONE with a start pulse while busy");
    applyStimulus(0, 3);
    // The memory now disagrees at 0x04 and 0x08.
    mem[4] = 32'd3; mem[8] = 32'd5;
    $display("[TB] fixed table, two mismatches");
    applyStimulus(0, -1);
    mem[4] = 32'd1; mem[8] = 32'd2;
    applyStimulus(0, -1);

    // Reset during WAIT of vector 2 (SETTLE 4 cycles, then 2 cycles per vector).
    @(negedge clk);
    start[0] = 1'b1;
    @(posedge clk);
    #1;
    start[0] = 1'b0;
    repeat (9) @(posedge clk);
    #1;
    checkOutput("midrun_vec_idx", 32'(vec_idx[0]), 32'd2);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    checkReset(0);

    // Give addresses 0x00/0x04/0x08 back their unique words before the
    // randomized runs.
    mem[0] = {mem[0][31:8] ^ 24'h5A5A5A, 8'h00};
    mem[4] = {24'h123456, 8'h04};
    mem[8] = {24'h654321, 8'h08};

    $display("[TB] read latency 3, random tables");
    for (int rep = 0; rep < 4; rep++) begin
      fillTable(4, 40);
      applyStimulus(1, -1);
    end
    fillTable(4, 0);
    applyStimulus(1, -1);

    $display("[TB] DUT latency shorter than memory latency");
    fillTable(4, 0);
    applyStimulus(2, -1);

    $display("[TB] empty table");
    applyStimulus(3, -1);
    applyStimulus(3, -1);

    $display("[TB] 255 vectors, all wrong, then sparse errors");
    fillTable(255, 100);
    applyStimulus(4, -1);
    fillTable(255, 3);
    applyStimulus(4, -1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
